// File: rtl/clkdiv_sched_if.sv
// clkdiv_sched_if: control/status bundle between the system controller and
// the slow-clock divider.
//
// Optional build macro: CLKDIV_SCHED_EDGE_CNT_EN adds the edge_cnt status field.
//
// Signals:
//   cfg_valid / cfg_half / cfg_ready : configuration handshake.
//   start / stop                     : one-cycle run control requests.
//   busy / clk_out / tick            : divider status and outputs.
//   dbg_state                        : FSM state, for debug and checkers.
//   edge_cnt                         : clk_out rising-edge count (macro only).
//
// Handshake: a configuration word transfers on a sysclk edge where cfg_valid
// and cfg_ready are both 1. The master may hold cfg_valid; cfg_half must be
// stable while cfg_valid is high. cfg_ready does not depend on cfg_valid.
interface clkdiv_sched_if #(
  parameter int CNT_W = 24
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             busy;
  logic             clk_out;
  logic             tick;
  logic [1:0]       dbg_state;
`ifdef CLKDIV_SCHED_EDGE_CNT_EN
  logic [31:0]      edge_cnt;

  modport master (output cfg_valid, cfg_half, start, stop,
                  input  cfg_ready, busy, clk_out, tick, dbg_state, edge_cnt);
  modport slave  (input  cfg_valid, cfg_half, start, stop,
                  output cfg_ready, busy, clk_out, tick, dbg_state, edge_cnt);
`else
  modport master (output cfg_valid, cfg_half, start, stop,
                  input  cfg_ready, busy, clk_out, tick, dbg_state);
  modport slave  (input  cfg_valid, cfg_half, start, stop,
                  output cfg_ready, busy, clk_out, tick, dbg_state);
`endif
endinterface

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: run-time controller for the slow-clock divider. A half-period
// counter toggles clk_out every half_r+1 sysclk cycles; start/stop and
// reconfiguration are sequenced so that clk_out never shows a truncated
// high pulse and a running phase is never resized.
//
// Optional build macro: CLKDIV_SCHED_EDGE_CNT_EN adds a 32-bit wrapping count
// of clk_out rising edges (bus.edge_cnt), cleared only by rst_n.
//
// Ports:
//   sysclk : system clock, all logic on posedge.
//   rst_n  : asynchronous active-low reset.
//   bus    : clkdiv_sched_if slave modport (config handshake, start/stop,
//            busy, clk_out, tick, dbg_state).
module clkdiv_sched #(
  parameter int          CNT_W        = 24,
  parameter int unsigned DEFAULT_HALF = 32'd12500000
) (
  input  logic           sysclk,
  input  logic           rst_n,
  clkdiv_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] pend_q;
  logic             pend_v_q;
  logic             clk_out_q;
  logic             tick_q;

  logic             boundary_d;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_inc_d;

  // Last cycle of the current clk_out phase.
  assign boundary_d = (state_q != ST_IDLE) && (cnt_q == half_q);
  // A rise only happens from RUN; a stop in the same cycle suppresses it.
  assign rise_d     = (state_q == ST_RUN) && boundary_d && !clk_out_q && !bus.stop;
  assign cnt_inc_d  = cnt_q + CNT_W'(1);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      half_q    <= CNT_W'(DEFAULT_HALF);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= rise_d;

      // Accept only while nothing is pending; a value accepted in a boundary
      // cycle has pend_v_q low there, so it waits for the next boundary.
      if (bus.cfg_valid && !pend_v_q) begin
        pend_q   <= bus.cfg_half;
        pend_v_q <= 1'b1;
      end else if (pend_v_q && ((state_q == ST_IDLE) || boundary_d)) begin
        half_q   <= pend_q;
        pend_v_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          if (bus.start && !bus.stop) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop && !clk_out_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (boundary_d) begin
            cnt_q     <= '0;
            clk_out_q <= !clk_out_q;
            // Stop while high at the boundary: the falling toggle ends the run.
            if (bus.stop) state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc_d;
            // Stop mid high phase: finish the phase before going idle.
            if (bus.stop) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (boundary_d) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLKDIV_SCHED_EDGE_CNT_EN
  logic [31:0] edge_cnt_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
    end else if (rise_d) begin
      edge_cnt_q <= edge_cnt_q + 32'd1;
    end
  end

  assign bus.edge_cnt = edge_cnt_q;
`endif

  assign bus.cfg_ready = !pend_v_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/clkdiv_sched.md
Name: clkdiv_sched

Overview:
- Run-time controller for the board's slow-clock divider. Owns a programmable half-period counter and sequences its start, stop and reconfiguration.
- Derives clk_out and a one-cycle tick from sysclk.
- Guarantees clk_out never produces a truncated high pulse.
- Sits between the system controller (config/start/stop) and the logic consuming the slow clock or tick.

Parameters:
- CNT_W, 24: width of the half-period counter and of cfg_half.
- DEFAULT_HALF, 12500000: half_r value after reset. Each clk_out phase lasts half_r+1 sysclk cycles. Must fit in CNT_W bits.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  new half-period offered.
- cfg_half  in  CNT_W  requested half_r value; sampled on handshake.
- cfg_ready  out  1  high when no configuration is pending.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle stop request.
- busy  out  1  high when state is not IDLE.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse, high in the same cycle clk_out becomes 1.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE, cnt=0, clk_out=0, tick=0, busy=0.
  - half_r=DEFAULT_HALF, pend_v=0, cfg_ready=1.
  - Any pending config is discarded.
- Boundary: cycle in which state is RUN or DRAIN and cnt==half_r. Next edge: cnt<=0 and clk_out toggles. Otherwise, in RUN/DRAIN, cnt<=cnt+1.
- cfg_half=0 is legal: toggle every cycle (divide by 2).
- Config handshake:
  - Accept when cfg_valid & cfg_ready: pend_r<=cfg_half, pend_v<=1, cfg_ready<=0.
  - In IDLE: half_r<=pend_r on the next edge; pend_v clears.
  - In RUN/DRAIN: applied only at a boundary. New half_r governs the phase starting at that boundary. The current phase is never shortened or lengthened.
  - Handshake in a boundary cycle: the value is applied at the following boundary.
  - cfg_ready returns to 1 on the edge that applies the value.
- FSM:
  - IDLE: cnt=0, clk_out=0.
    - start & !stop -> RUN, cnt=0.
    - start & stop: stop wins; remain in IDLE.
    - stop alone: ignored.
  - RUN:
    - stop with clk_out=0 -> IDLE next edge; cnt<=0, clk_out stays 0.
    - stop with clk_out=1 -> DRAIN.
    - start: ignored.
  - DRAIN: counts normally; start and stop ignored. At the boundary: clk_out<=0, cnt<=0, state<=IDLE on the same edge.
- stop coinciding with a boundary in RUN:
  - clk_out=0: goes to IDLE with clk_out held 0; no rise, no tick.
  - clk_out=1: the falling toggle happens and state goes to IDLE directly.
- tick<=1 exactly on edges where clk_out goes 0->1; otherwise 0.
- busy is registered from the state encoding; it drops on the same edge IDLE is entered.
- Latency: the first clk_out rise occurs half_r+1 cycles after the RUN-entry edge.

Optional Feature:
- Macro: CLKDIV_SCHED_EDGE_CNT_EN.
- Defined:
  - Extra output edge_cnt [31:0] counts clk_out rising edges and wraps 0xFFFFFFFF->0.
  - Reset to 0 by rst_n only; holds its value across stop/start.
- Undefined: no edge_cnt port and no counter logic. All other behaviour identical.

Test Plan:
- Defaults with DEFAULT_HALF=3:
  - During reset, check clk_out=0, busy=0, cfg_ready=1.
  - start -> clk_out rises 4 cycles after RUN entry; period 8 cycles; tick high one cycle per rise.
  - With the macro defined, edge_cnt=3 after three rises.
- Reconfig while running: half_r=3, clk_out high at cnt=1, offer cfg_half=1.
  - cfg_ready drops next edge.
  - Current high phase still lasts 4 cycles, then phases last 2 cycles.
  - cfg_ready=1 at the applying boundary.
- Stop while high: stop at cnt=1 with clk_out=1 -> DRAIN.
  - clk_out falls at the boundary (high phase 4 cycles total); busy drops on the same edge; no further ticks.
- Stop while low: stop with clk_out=0 -> busy=0 next edge, clk_out remains 0.
  - Simultaneous start & stop in IDLE -> stays IDLE.
- Divide-by-2: cfg_half=0 in IDLE, then start -> clk_out toggles every cycle, tick every 2 cycles.
  - Handshake in a boundary cycle is applied one boundary later.
- Reset mid-run: rst_n low during RUN with pend_v=1 -> outputs clear immediately (asynchronously).
  - After release: half_r=DEFAULT_HALF, cfg_ready=1, state IDLE.
